// File: rtl/frame_receiver_pkg.sv
// Shared configuration for the frame receiver: default geometry, pixel type and FSM state type.
package frame_receiver_pkg;

  localparam int CFG_PIXEL_ARRAY_WIDTH  = 4;
  localparam int CFG_PIXEL_ARRAY_HEIGHT = 4;
  localparam int CFG_OUTPUT_BUS_WIDTH   = 2;
  localparam int CFG_PIXEL_BITS         = 8;
  localparam int FRAME_PIXELS           = CFG_PIXEL_ARRAY_WIDTH * CFG_PIXEL_ARRAY_HEIGHT;

  typedef logic [CFG_PIXEL_BITS-1:0] pixel_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_RECV  = 2'd1,
    RX_READY = 2'd2,
    RX_ERROR = 2'd3
  } rx_state_t;

endpackage

// File: rtl/frame_receiver_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector with a registered one-cycle pulse.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;

  // Synchronise the async strobe and emit one pulse per rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/frame_receiver.sv
// Reassembles sensor output beats into a frame store readable by the host.
// Optional FRAME_RX_CHECKSUM_EN adds a 16-bit running pixel sum output CHECKSUM.
module frame_receiver
  import frame_receiver_pkg::*;
#(
  parameter int PIXEL_ARRAY_WIDTH  = CFG_PIXEL_ARRAY_WIDTH,
  parameter int PIXEL_ARRAY_HEIGHT = CFG_PIXEL_ARRAY_HEIGHT,
  parameter int OUTPUT_BUS_WIDTH   = CFG_OUTPUT_BUS_WIDTH,
  parameter int PIXEL_BITS         = CFG_PIXEL_BITS
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic                                         OUTPUT_CLK,
  input  logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]  DATA_IN,
  input  logic                                         FRAME_FINISHED,
  input  logic                                         FRAME_ACK,
  input  logic [$clog2(PIXEL_ARRAY_WIDTH*PIXEL_ARRAY_HEIGHT)-1:0] RD_ADDR,
  output logic [PIXEL_BITS-1:0]                        RD_DATA,
  output logic                                         FRAME_READY,
  output logic                                         FRAME_ERROR,
  output logic [7:0]                                   FRAME_COUNT
`ifdef FRAME_RX_CHECKSUM_EN
  ,
  output logic [15:0]                                  CHECKSUM
`endif
);

  localparam int W    = PIXEL_ARRAY_WIDTH;
  localparam int H    = PIXEL_ARRAY_HEIGHT;
  localparam int BUS  = OUTPUT_BUS_WIDTH;
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(W + 1);
  localparam int RW   = $clog2(H + 1);
  localparam int PW   = $clog2(NPIX + 1);

  logic                  beat_evt_s;
  logic                  end_evt_s;
  logic                  accept_s;
  logic [AW-1:0]         wr_base_s;

  rx_state_t             state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            count_q, count_d;
  logic                  frame_ready_q;
  logic                  frame_error_q;
  logic [PIXEL_BITS-1:0] rd_data_q;
  logic [PIXEL_BITS-1:0] store_q [NPIX];

  edge_sync u_beat_sync (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .async_i (OUTPUT_CLK),
    .pulse_o (beat_evt_s)
  );

  edge_sync u_end_sync (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .async_i (FRAME_FINISHED),
    .pulse_o (end_evt_s)
  );

  // A beat is stored only while collecting and the frame is not yet full.
  assign accept_s  = beat_evt_s &&
                     ((state_q == RX_IDLE) || ((state_q == RX_RECV) && (cnt_q != PW'(NPIX))));
  assign wr_base_s = AW'(int'(row_q) * W + int'(col_q));

`ifdef FRAME_RX_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
  logic [15:0] beat_sum_s;

  // Sum of the pixels carried by the current beat.
  always_comb begin
    beat_sum_s = 16'd0;
    for (int i = 0; i < BUS; i++) begin
      beat_sum_s = beat_sum_s + 16'(DATA_IN[i]);
    end
  end
`endif

  // Next-state logic; the beat of a coincident end event is counted before the check.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    count_d = count_q;
`ifdef FRAME_RX_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      RX_IDLE, RX_RECV: begin
        if (accept_s) begin
          state_d = RX_RECV;
          cnt_d   = cnt_q + PW'(BUS);
`ifdef FRAME_RX_CHECKSUM_EN
          csum_d  = csum_q + beat_sum_s;
`endif
          if (col_q + CW'(BUS) == CW'(W)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(BUS);
          end
        end else if (beat_evt_s) begin
          ovf_d = 1'b1;
        end else begin
          ovf_d = ovf_q;
        end
        if (end_evt_s) begin
          if ((cnt_d == PW'(NPIX)) && !ovf_d) begin
            state_d = RX_READY;
            count_d = count_q + 8'd1;
          end else begin
            state_d = RX_ERROR;
          end
        end else begin
          count_d = count_q;
        end
      end
      RX_READY, RX_ERROR: begin
        if (FRAME_ACK) begin
          state_d = RX_IDLE;
          col_d   = '0;
          row_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
`ifdef FRAME_RX_CHECKSUM_EN
          csum_d  = 16'd0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // FSM state, frame bookkeeping and registered status outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= RX_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      count_q       <= 8'd0;
      frame_ready_q <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef FRAME_RX_CHECKSUM_EN
      csum_q        <= 16'd0;
`endif
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      count_q       <= count_d;
      frame_ready_q <= (state_d == RX_READY);
      frame_error_q <= (state_d == RX_ERROR);
`ifdef FRAME_RX_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Frame store write port; contents deliberately survive reset.
  always_ff @(posedge CLK) begin
    if (!RESET && accept_s) begin
      for (int i = 0; i < BUS; i++) begin
        store_q[wr_base_s + AW'(i)] <= DATA_IN[i];
      end
    end
  end

  // Host read port, one cycle of latency.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_data_q <= '0;
    end else if (int'(RD_ADDR) < NPIX) begin
      rd_data_q <= store_q[RD_ADDR];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign RD_DATA     = rd_data_q;
  assign FRAME_READY = frame_ready_q;
  assign FRAME_ERROR = frame_error_q;
  assign FRAME_COUNT = count_q;
`ifdef FRAME_RX_CHECKSUM_EN
  assign CHECKSUM    = csum_q;
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver with a transaction-level frame model and per-cycle compare.
module tb_frame_receiver;
  import frame_receiver_pkg::*;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             OUTPUT_CLK = 1'b0;
  logic [1:0][7:0]  DATA_IN = '0;
  logic             FRAME_FINISHED = 1'b0;
  logic             FRAME_ACK = 1'b0;
  logic [3:0]       RD_ADDR = 4'd0;
  logic [7:0]       RD_DATA;
  logic             FRAME_READY;
  logic             FRAME_ERROR;
  logic [7:0]       FRAME_COUNT;
`ifdef FRAME_RX_CHECKSUM_EN
  logic [15:0]      CHECKSUM;
`endif

  frame_receiver dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .OUTPUT_CLK     (OUTPUT_CLK),
    .DATA_IN        (DATA_IN),
    .FRAME_FINISHED (FRAME_FINISHED),
    .FRAME_ACK      (FRAME_ACK),
    .RD_ADDR        (RD_ADDR),
    .RD_DATA        (RD_DATA),
    .FRAME_READY    (FRAME_READY),
    .FRAME_ERROR    (FRAME_ERROR),
    .FRAME_COUNT    (FRAME_COUNT)
`ifdef FRAME_RX_CHECKSUM_EN
    ,
    .CHECKSUM       (CHECKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;
  bit busy = 1'b1;

  // Frame model: 0 idle, 1 receiving, 2 ready, 3 error; pixels fill linearly.
  int     m_st = 0;
  int     m_cnt = 0;
  bit     m_ovf = 1'b0;
  int     m_count = 0;
  int     m_sum = 0;
  pixel_t m_mem [16];
  bit     m_val [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_beat(input pixel_t p0, input pixel_t p1);
    if (m_st == 0 || m_st == 1) begin
      if (m_cnt < 16) begin
        m_mem[m_cnt] = p0;     m_val[m_cnt] = 1'b1;
        m_mem[m_cnt + 1] = p1; m_val[m_cnt + 1] = 1'b1;
        m_cnt = m_cnt + 2;
        m_sum = (m_sum + int'(p0) + int'(p1)) % 65536;
        m_st = 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic m_end();
    if (m_st == 0 || m_st == 1) begin
      if (m_cnt == 16 && !m_ovf) begin
        m_st = 2;
        m_count = (m_count + 1) % 256;
      end else begin
        m_st = 3;
      end
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Per-cycle comparison whenever inputs have been quiet long enough to settle.
  logic [3:0] last_addr = 4'd0;
  always @(posedge CLK) last_addr <= RD_ADDR;

  int quiet = 0;
  always @(negedge CLK) begin
    if (started && !busy && !RESET) begin
      if (quiet >= 2) begin
        chk("ready", {31'd0, FRAME_READY}, {31'd0, m_st == 2});
        chk("error", {31'd0, FRAME_ERROR}, {31'd0, m_st == 3});
        chk("count", {24'd0, FRAME_COUNT}, m_count);
        if (m_val[last_addr]) chk("rd_data", {24'd0, RD_DATA}, {24'd0, m_mem[last_addr]});
`ifdef FRAME_RX_CHECKSUM_EN
        chk("checksum", {16'd0, CHECKSUM}, m_sum);
`endif
      end
      quiet = quiet + 1;
    end else begin
      quiet = 0;
    end
  end

  // One sensor strobe: optional beat and/or end rise in the same cycle; returns status latency.
  task automatic strobe(input bit do_beat, input bit do_end, input pixel_t p0, input pixel_t p1,
                        output int lat);
    busy = 1'b1;
    DATA_IN[0] = p0;
    DATA_IN[1] = p1;
    if (do_beat) begin OUTPUT_CLK = 1'b1; m_beat(p0, p1); end
    if (do_end) begin FRAME_FINISHED = 1'b1; m_end(); end
    lat = 99;
    for (int i = 1; i <= 7; i++) begin
      cyc();
      if (lat == 99 && (FRAME_READY || FRAME_ERROR)) lat = i;
    end
    OUTPUT_CLK = 1'b0;
    FRAME_FINISHED = 1'b0;
    cyc();
    cyc();
    busy = 1'b0;
  endtask

  // Sends nbeats beats of base+k; end_mode 0 none, 1 after last beat, 2 with last beat.
  task automatic send_frame(input pixel_t base, input int nbeats, input int end_mode, output int lat);
    int l;
    lat = 99;
    for (int b = 0; b < nbeats; b++) begin
      strobe(1'b1, (end_mode == 2) && (b == nbeats - 1),
             pixel_t'(base + 8'(2 * b)), pixel_t'(base + 8'(2 * b + 1)), l);
      if (end_mode == 2) lat = l;
    end
    if (end_mode == 1) strobe(1'b0, 1'b1, 8'h00, 8'h00, lat);
  endtask

  task automatic do_ack();
    busy = 1'b1;
    FRAME_ACK = 1'b1;
    if (m_st == 2 || m_st == 3) begin
      m_st = 0; m_cnt = 0; m_ovf = 1'b0; m_sum = 0;
    end
    cyc();
    cyc();
    FRAME_ACK = 1'b0;
    cyc();
    cyc();
    busy = 1'b0;
  endtask

  task automatic do_reset();
    busy = 1'b1;
    RESET = 1'b1;
    m_st = 0; m_cnt = 0; m_ovf = 1'b0; m_count = 0; m_sum = 0;
    cyc();
    cyc();
    RESET = 1'b0;
    cyc();
    busy = 1'b0;
  endtask

  task automatic readback(input string name, input pixel_t base);
    for (int k = 0; k < 16; k++) begin
      RD_ADDR = 4'(k);
      cyc();
      chk(name, {24'd0, RD_DATA}, {24'd0, pixel_t'(base + 8'(k))});
    end
  endtask

  initial begin
    int lat;
    cyc();
    cyc();
    chk("reset_ready", {31'd0, FRAME_READY}, 32'd0);
    chk("reset_error", {31'd0, FRAME_ERROR}, 32'd0);
    chk("reset_count", {24'd0, FRAME_COUNT}, 32'd0);
    chk("reset_rd_data", {24'd0, RD_DATA}, 32'd0);
    RESET = 1'b0;
    cyc();
    started = 1'b1;
    busy = 1'b0;
    cyc();

    // Short frame: 7 beats then end.
    send_frame(8'h50, 7, 1, lat);
    chk("short_error", {31'd0, FRAME_ERROR}, 32'd1);
    chk("short_count", {24'd0, FRAME_COUNT}, 32'd0);
    do_ack();
    chk("short_ack_error", {31'd0, FRAME_ERROR}, 32'd0);

    // Good frame 0..15.
    send_frame(8'h00, 8, 1, lat);
    chk("good_latency", {31'd0, lat <= 4}, 32'd1);
    chk("good_ready", {31'd0, FRAME_READY}, 32'd1);
    chk("good_count", {24'd0, FRAME_COUNT}, 32'd1);
`ifdef FRAME_RX_CHECKSUM_EN
    chk("good_checksum", {16'd0, CHECKSUM}, 32'd120);
`endif
    readback("good_data", 8'h00);

    // Beats while READY must leave the store alone.
    send_frame(8'hFF, 8, 0, lat);
    readback("frozen_data", 8'h00);
    do_ack();
    send_frame(8'h40, 8, 1, lat);
    chk("second_count", {24'd0, FRAME_COUNT}, 32'd2);
    readback("second_data", 8'h40);
    do_ack();

    // Overflow: 9 beats, the 9th is discarded.
    send_frame(8'h80, 8, 0, lat);
    strobe(1'b1, 1'b0, 8'hAA, 8'hAB, lat);
    strobe(1'b0, 1'b1, 8'h00, 8'h00, lat);
    chk("ovf_error", {31'd0, FRAME_ERROR}, 32'd1);
    RD_ADDR = 4'd15;
    cyc();
    chk("ovf_addr15", {24'd0, RD_DATA}, 32'h8F);
    do_ack();

    // Reset mid-frame, then a full good frame.
    send_frame(8'hC0, 4, 0, lat);
    do_reset();
    send_frame(8'h10, 8, 1, lat);
    chk("after_reset_ready", {31'd0, FRAME_READY}, 32'd1);
    chk("after_reset_count", {24'd0, FRAME_COUNT}, 32'd1);
    readback("after_reset_data", 8'h10);
    do_ack();

    // Last beat and end rise in the same cycle.
    send_frame(8'h20, 8, 2, lat);
    chk("coincident_latency", {31'd0, lat <= 4}, 32'd1);
    chk("coincident_ready", {31'd0, FRAME_READY}, 32'd1);
    chk("coincident_error", {31'd0, FRAME_ERROR}, 32'd0);
    chk("coincident_count", {24'd0, FRAME_COUNT}, 32'd2);
    readback("coincident_data", 8'h20);

    repeat (4) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
